// File: rtl/pcie_cpl_scheduler.sv
// pcie_cpl_scheduler
// Buffers decoded MRd requests from the RX decoder and hands them to the
// completion encoder strictly one at a time. Each issued request is held until
// its completion TLP starts on the link (or a timeout expires), followed by a
// short idle gap. Requests with unsupported first-DW byte enables are dropped
// and counted.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | nothing outstanding; issue when queue non-empty and no wait
// ST_ISSUE | enc_read_req strobe high, enc_* fields valid, head popped
// ST_WAIT  | waiting for completion SOP; timeout timer running
// ST_GAP   | enforced idle gap after completion/timeout; frozen by wait

module pcie_cpl_scheduler #(
    parameter int FIFO_DEPTH  = 4,
    parameter int CPL_TIMEOUT = 32,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        rx_req_valid,
    output logic                        rx_req_ready,
    input  logic [15:0]                 rx_req_addr,
    input  logic [3:0]                  rx_req_be,
    input  logic [7:0]                  rx_req_tag,
    input  logic [15:0]                 rx_req_rid,
    output logic                        enc_read_req,
    output logic [15:0]                 enc_read_addr,
    output logic [3:0]                  enc_bit_enable,
    output logic [7:0]                  enc_tag,
    output logic [15:0]                 enc_requester_id,
    input  logic                        enc_tx_sop,
    input  logic                        tl_tx_wait,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] pending,
    output logic [7:0]                  drop_cnt,
    output logic [7:0]                  timeout_cnt,
    output logic                        err_timeout
);

    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int EW      = 44;
    localparam int CNT_MAX = (CPL_TIMEOUT > GAP_CYCLES) ? CPL_TIMEOUT : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    // The timer is a down-counter: loaded with (length-1), terminal at zero.
    localparam logic [CW-1:0] TO_LOAD  = CW'(CPL_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    // queue storage, entry layout {rid, tag, be, addr}
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [EW-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ready_q, ready_d;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic [EW-1:0] fields_q, fields_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [7:0]    to_cnt_q, to_cnt_d;

    logic          be_ok;
    logic          accept;
    logic          push;
    logic          drop;
    logic          pop;
    logic          cpl_seen;
    logic          timeout;
    logic [EW-1:0] rx_entry;

    assign be_ok    = (rx_req_be == 4'b0001) || (rx_req_be == 4'b1111);
    assign accept   = rx_req_valid & ready_q;
    assign push     = accept & be_ok;
    assign drop     = accept & ~be_ok;
    assign rx_entry = {rx_req_rid, rx_req_tag, rx_req_be, rx_req_addr};

    // An SOP seen while the link is stalled is the encoder replaying a
    // packet, not a new completion, so it does not end the wait.
    assign cpl_seen = enc_tx_sop & ~tl_tx_wait;

    // Issue sequencing: one request outstanding, timeout, then idle gap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = 1'b0;
        fields_d = fields_q;
        pop      = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((count_q != '0) && !tl_tx_wait) begin
                    state_d  = ST_ISSUE;
                    req_d    = 1'b1;
                    fields_d = mem_q[rd_ptr_q];
                    pop      = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
                cnt_d   = TO_LOAD;
            end
            ST_WAIT: begin
                if (cpl_seen) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                    timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (!tl_tx_wait) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Queue pointers, occupancy and the registered ready flag.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = rx_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        ready_d = (count_d < DEPTH_C);
    end

    // Saturating drop and timeout statistics.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        to_cnt_d   = to_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        if (timeout && (to_cnt_q != 8'hFF)) begin
            to_cnt_d = to_cnt_q + 8'd1;
        end
    end

    // State registers; reset drops anything queued or in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            fields_q   <= '0;
            drop_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            fields_q   <= fields_d;
            drop_cnt_q <= drop_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign rx_req_ready     = ready_q;
    assign enc_read_req     = req_q;
    assign enc_read_addr    = fields_q[15:0];
    assign enc_bit_enable   = fields_q[19:16];
    assign enc_tag          = fields_q[27:20];
    assign enc_requester_id = fields_q[43:28];
    assign busy             = (state_q != ST_IDLE);
    assign pending          = count_q;
    assign drop_cnt         = drop_cnt_q;
    assign timeout_cnt      = to_cnt_q;
    assign err_timeout      = timeout;

endmodule

// File: tb/tb_pcie_cpl_scheduler.sv
// Testbench for pcie_cpl_scheduler: directed scenarios plus a randomized
// phase, every cycle compared against a queue-based reference model.

module tb_pcie_cpl_scheduler;

    localparam int FIFO_DEPTH  = 4;
    localparam int CPL_TIMEOUT = 32;
    localparam int GAP_CYCLES  = 4;

    localparam int P_IDLE  = 0;
    localparam int P_ISSUE = 1;
    localparam int P_WAIT  = 2;
    localparam int P_GAP   = 3;

    typedef struct packed {
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [3:0]  be;
        logic [15:0] addr;
    } req_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rx_req_valid = 1'b0;
    logic        rx_req_ready;
    logic [15:0] rx_req_addr = '0;
    logic [3:0]  rx_req_be = '0;
    logic [7:0]  rx_req_tag = '0;
    logic [15:0] rx_req_rid = '0;
    logic        enc_read_req;
    logic [15:0] enc_read_addr;
    logic [3:0]  enc_bit_enable;
    logic [7:0]  enc_tag;
    logic [15:0] enc_requester_id;
    logic        enc_tx_sop = 1'b0;
    logic        tl_tx_wait = 1'b0;
    logic        busy;
    logic [2:0]  pending;
    logic [7:0]  drop_cnt;
    logic [7:0]  timeout_cnt;
    logic        err_timeout;

    always #5 clk = ~clk;

    pcie_cpl_scheduler #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CPL_TIMEOUT(CPL_TIMEOUT),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .rx_req_valid    (rx_req_valid),
        .rx_req_ready    (rx_req_ready),
        .rx_req_addr     (rx_req_addr),
        .rx_req_be       (rx_req_be),
        .rx_req_tag      (rx_req_tag),
        .rx_req_rid      (rx_req_rid),
        .enc_read_req    (enc_read_req),
        .enc_read_addr   (enc_read_addr),
        .enc_bit_enable  (enc_bit_enable),
        .enc_tag         (enc_tag),
        .enc_requester_id(enc_requester_id),
        .enc_tx_sop      (enc_tx_sop),
        .tl_tx_wait      (tl_tx_wait),
        .busy            (busy),
        .pending         (pending),
        .drop_cnt        (drop_cnt),
        .timeout_cnt     (timeout_cnt),
        .err_timeout     (err_timeout)
    );

    int checks   = 0;
    int failures = 0;

    // reference model
    req_t       mq[$];
    req_t       m_cur;
    int         m_phase;
    int         m_waited;
    int         m_gap_left;
    int         m_drop;
    int         m_to;
    bit         m_ready;
    bit         last_acc;
    logic [7:0] dut_tags[$];

    logic [3:0] be_tab [0:5] = '{4'h1, 4'hF, 4'h3, 4'h0, 4'h8, 4'hF};

    function automatic bit be_good(input logic [3:0] b);
        return (b == 4'b0001) || (b == 4'b1111);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cur      = '0;
        m_phase    = P_IDLE;
        m_waited   = 0;
        m_gap_left = 0;
        m_drop     = 0;
        m_to       = 0;
        m_ready    = 1'b0;
        last_acc   = 1'b0;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_ready"}, rx_req_ready, 0);
        chk({pfx, "_req"}, enc_read_req, 0);
        chk({pfx, "_fields"}, {enc_requester_id, enc_tag, enc_bit_enable, enc_read_addr}, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_pending"}, pending, 0);
        chk({pfx, "_drop"}, drop_cnt, 0);
        chk({pfx, "_tocnt"}, timeout_cnt, 0);
        chk({pfx, "_err"}, err_timeout, 0);
    endtask

    // One clock cycle: check combinational outputs mid-cycle, advance the
    // model across the edge, then check the registered outputs.
    task automatic tick();
        bit   s_v;
        bit   s_sop;
        bit   s_w;
        bit   cpl;
        bit   err_exp;
        req_t s_req;
        @(negedge clk);
        s_v   = rx_req_valid;
        s_sop = enc_tx_sop;
        s_w   = tl_tx_wait;
        s_req = '{rid: rx_req_rid, tag: rx_req_tag, be: rx_req_be, addr: rx_req_addr};
        cpl   = s_sop && !s_w;
        if (rstn) begin
            err_exp = (m_phase == P_WAIT) && !cpl && (m_waited + 1 == CPL_TIMEOUT);
            chk("err_timeout", err_timeout, err_exp);
            chk("rx_req_ready_mid", rx_req_ready, m_ready);
        end
        @(posedge clk);
        #1;
        if (!rstn) begin
            m_ready  = 1'b0;
            last_acc = 1'b0;
            return;
        end
        case (m_phase)
            P_IDLE: begin
                if (mq.size() > 0 && !s_w) begin
                    m_cur   = mq.pop_front();
                    m_phase = P_ISSUE;
                end
            end
            P_ISSUE: begin
                m_phase  = P_WAIT;
                m_waited = 0;
            end
            P_WAIT: begin
                if (cpl) begin
                    m_phase    = P_GAP;
                    m_gap_left = GAP_CYCLES;
                end else if (m_waited + 1 == CPL_TIMEOUT) begin
                    m_phase    = P_GAP;
                    m_gap_left = GAP_CYCLES;
                    if (m_to < 255) m_to++;
                end else begin
                    m_waited++;
                end
            end
            default: begin
                if (!s_w) begin
                    m_gap_left--;
                    if (m_gap_left == 0) m_phase = P_IDLE;
                end
            end
        endcase
        last_acc = s_v && m_ready;
        if (last_acc) begin
            if (be_good(s_req.be)) mq.push_back(s_req);
            else if (m_drop < 255) m_drop++;
        end
        m_ready = (mq.size() < FIFO_DEPTH);
        if (enc_read_req === 1'b1) dut_tags.push_back(enc_tag);
        chk("enc_read_req", enc_read_req, (m_phase == P_ISSUE));
        chk("enc_fields", {enc_requester_id, enc_tag, enc_bit_enable, enc_read_addr},
            {m_cur.rid, m_cur.tag, m_cur.be, m_cur.addr});
        chk("busy", busy, (m_phase != P_IDLE));
        chk("pending", pending, mq.size());
        chk("rx_req_ready", rx_req_ready, m_ready);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("timeout_cnt", timeout_cnt, m_to);
    endtask

    task automatic do_reset();
        rx_req_valid = 1'b0;
        enc_tx_sop   = 1'b0;
        tl_tx_wait   = 1'b0;
        rstn         = 1'b0;
        #1;
        model_reset();
        dut_tags.delete();
        tick();
        chk_zero("rst");
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic push_one(input logic [15:0] a, input logic [3:0] b,
                            input logic [7:0] t, input logic [15:0] r);
        int n;
        rx_req_addr  = a;
        rx_req_be    = b;
        rx_req_tag   = t;
        rx_req_rid   = r;
        rx_req_valid = 1'b1;
        last_acc     = 1'b0;
        n            = 0;
        while (!last_acc && n < 200) begin
            tick();
            n++;
        end
        rx_req_valid = 1'b0;
        chk("push_bound", last_acc, 1);
    endtask

    task automatic wait_issue();
        int n;
        n = 0;
        while (enc_read_req !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("wait_issue_bound", enc_read_req, 1);
    endtask

    task automatic count_to_issue(output int n);
        n = 0;
        while (enc_read_req !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic drain();
        int n;
        rx_req_valid = 1'b0;
        tl_tx_wait   = 1'b0;
        n            = 0;
        while ((mq.size() > 0 || m_phase != P_IDLE) && n < 3000) begin
            enc_tx_sop = ($urandom_range(0, 99) < 30);
            tick();
            n++;
        end
        enc_tx_sop = 1'b0;
        chk("drain_busy", busy, 0);
        chk("drain_pending", pending, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // 1: single request, latency, completion and gap
        do_reset();
        push_one(16'h0010, 4'hF, 8'h05, 16'h0100);
        chk("t1_not_yet", enc_read_req, 0);
        tick();
        chk("t1_issue", enc_read_req, 1);
        chk("t1_fields", {enc_requester_id, enc_tag, enc_bit_enable, enc_read_addr},
            {16'h0100, 8'h05, 4'hF, 16'h0010});
        repeat (13) tick();
        enc_tx_sop = 1'b1;
        tick();
        enc_tx_sop = 1'b0;
        chk("t1_gap_busy", busy, 1);
        repeat (3) tick();
        chk("t1_gap_end_busy", busy, 1);
        tick();
        chk("t1_idle_busy", busy, 0);
        chk("t1_fields_held", {enc_tag, enc_read_addr}, {8'h05, 16'h0010});

        // 2: fill queue under backpressure, fifth push held, in-order issue
        do_reset();
        tl_tx_wait = 1'b1;
        for (int i = 0; i < 4; i++) push_one(16'h1000 + 16'(i), 4'hF, 8'(i), 16'h0200);
        chk("t2_pending_full", pending, 4);
        chk("t2_ready_low", rx_req_ready, 0);
        rx_req_addr  = 16'h1004;
        rx_req_be    = 4'hF;
        rx_req_tag   = 8'd4;
        rx_req_rid   = 16'h0200;
        rx_req_valid = 1'b1;
        repeat (3) tick();
        chk("t2_held_pending", pending, 4);
        chk("t2_held_ready", rx_req_ready, 0);
        tl_tx_wait = 1'b0;
        last_acc   = 1'b0;
        n          = 0;
        while (!last_acc && n < 200) begin
            tick();
            n++;
        end
        rx_req_valid = 1'b0;
        chk("t2_fifth_accepted", last_acc, 1);
        drain();
        chk("t2_issue_count", dut_tags.size(), 5);
        for (int i = 0; i < dut_tags.size() && i < 5; i++) chk("t2_order", dut_tags[i], i);

        // 3: unsupported byte enable is dropped
        do_reset();
        push_one(16'h0300, 4'b0011, 8'h21, 16'h0300);
        tick();
        chk("t3_drop_cnt", drop_cnt, 1);
        chk("t3_pending", pending, 0);
        chk("t3_busy", busy, 0);
        push_one(16'h0304, 4'b0001, 8'h22, 16'h0300);
        tick();
        chk("t3_issue", enc_read_req, 1);
        chk("t3_tag", enc_tag, 8'h22);
        chk("t3_be", enc_bit_enable, 4'b0001);
        drain();

        // 4: timeout without completion, next request follows after gap
        do_reset();
        push_one(16'h0400, 4'hF, 8'h41, 16'h0400);
        push_one(16'h0404, 4'h1, 8'h42, 16'h0400);
        wait_issue();
        chk("t4_first_tag", enc_tag, 8'h41);
        repeat (31) tick();
        chk("t4_err_early", err_timeout, 0);
        tick();
        chk("t4_err_pulse", err_timeout, 1);
        tick();
        chk("t4_err_one_cycle", err_timeout, 0);
        chk("t4_tocnt", timeout_cnt, 1);
        count_to_issue(n);
        chk("t4_gap_cycles", n, 5);
        chk("t4_second_tag", enc_tag, 8'h42);
        drain();

        // 5: backpressure blocks issue and stretches the gap
        do_reset();
        tl_tx_wait = 1'b1;
        push_one(16'h0500, 4'hF, 8'h51, 16'h0500);
        push_one(16'h0504, 4'hF, 8'h52, 16'h0500);
        repeat (8) tick();
        chk("t5_no_issue", dut_tags.size(), 0);
        chk("t5_pending", pending, 2);
        tl_tx_wait = 1'b0;
        tick();
        chk("t5_issue_after_release", enc_read_req, 1);
        chk("t5_tag1", enc_tag, 8'h51);
        repeat (5) tick();
        enc_tx_sop = 1'b1;
        tick();
        enc_tx_sop = 1'b0;
        tl_tx_wait = 1'b1;
        repeat (3) tick();
        tl_tx_wait = 1'b0;
        count_to_issue(n);
        chk("t5_gap_stretched", n, 5);
        chk("t5_tag2", enc_tag, 8'h52);
        drain();

        // 6: reset during WAIT_CPL with requests queued
        do_reset();
        for (int i = 0; i < 4; i++) push_one(16'h0600 + 16'(i), 4'hF, 8'h61 + 8'(i), 16'h0600);
        chk("t6_pending", pending, 3);
        chk("t6_busy", busy, 1);
        chk("t6_tag", enc_tag, 8'h61);
        rstn = 1'b0;
        #1;
        chk_zero("t6_async");
        do_reset();
        enc_tx_sop = 1'b1;
        tick();
        enc_tx_sop = 1'b0;
        repeat (3) tick();
        chk("t6_late_sop_busy", busy, 0);
        chk("t6_late_sop_req", enc_read_req, 0);
        chk("t6_late_sop_tocnt", timeout_cnt, 0);

        // 7: randomized traffic against the model
        do_reset();
        repeat (800) begin
            rx_req_valid = ($urandom_range(0, 99) < 45);
            rx_req_addr  = 16'($urandom);
            rx_req_be    = be_tab[$urandom_range(0, 5)];
            rx_req_tag   = 8'($urandom);
            rx_req_rid   = 16'($urandom);
            enc_tx_sop   = ($urandom_range(0, 99) < 8);
            tl_tx_wait   = ($urandom_range(0, 99) < 15);
            tick();
        end
        enc_tx_sop = 1'b0;
        drain();

        // 8: counter saturation
        do_reset();
        rx_req_be    = 4'h3;
        rx_req_valid = 1'b1;
        repeat (260) tick();
        rx_req_valid = 1'b0;
        chk("t8_drop_sat", drop_cnt, 8'hFF);
        rx_req_be    = 4'hF;
        rx_req_valid = 1'b1;
        repeat (258 * (CPL_TIMEOUT + GAP_CYCLES + 2)) tick();
        rx_req_valid = 1'b0;
        chk("t8_timeout_sat", timeout_cnt, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
